// File: rtl/countdown_game_pkg.sv
// Shared types and helpers for the countdown game core: FSM states,
// seven-segment patterns, the scale-shift lookup and the switch popcount.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_RUN,
    ST_DONE
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}; element 0 is the pattern for digit 0.
  localparam logic [9:0][6:0] SEG_PAT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    return (digit > 4'd9) ? SEG_BLANK : SEG_PAT[digit];
  endfunction

  // mul_sel 00/01/10/11 scales by x1/x2/x8/x16.
  function automatic logic [2:0] mul_shift(input logic [1:0] sel);
    case (sel)
      2'b00:   return 3'd0;
      2'b01:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] popcount(input logic [63:0] bits);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'b0, bits[i]};
    return n;
  endfunction

endpackage

// File: rtl/countdown_game_if.sv
// Pin-side bundle of the countdown game: switches/buttons in, LEDs/display out.
interface countdown_game_if #(
   parameter int SW_W   = 8,
   parameter int DIGITS = 4
);
   localparam int CNT_W = $clog2(SW_W + 1) + 4;

   logic [SW_W-1:0]   sw;
   logic [1:0]        mul_sel;
   logic              load;
   logic              pause;
   logic [CNT_W-1:0]  led;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              busy;
   logic              done;

   modport master (output sw, mul_sel, load, pause,
                   input  led, seg, an, busy, done);
   modport slave  (input  sw, mul_sel, load, pause,
                   output led, seg, an, busy, done);
endinterface

// File: rtl/countdown_game_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, BIN_W
// steps after start. bcd shows the outcome of the step taken at the coming edge.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [BIN_W-1:0]    bin,
   output logic [4*DIGITS-1:0] bcd,
   output logic                valid
);
   localparam int BCD_W  = 4 * DIGITS;
   localparam int STEP_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]  bin_sh;
   logic [BCD_W-1:0]  acc;
   logic [BCD_W-1:0]  adj;
   logic [BCD_W-1:0]  acc_next;
   logic [STEP_W-1:0] step;
   logic              running;

   always_comb begin
      // NOTE: defaults first so a digit that needs no correction cannot infer a latch.
      adj = acc;
      for (int i = 0; i < DIGITS; i++)
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      acc_next = BCD_W'({adj, bin_sh[BIN_W-1]});
   end

   assign bcd   = acc_next;
   assign valid = running && (step == STEP_W'(BIN_W - 1));

   // NOTE: these are a handful of working registers, not a memory, so they take the async reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_sh  <= '0;
         acc     <= '0;
         step    <= '0;
         running <= 1'b0;
      end else if (start) begin
         bin_sh  <= bin;
         acc     <= '0;
         step    <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc     <= acc_next;
         bin_sh  <= bin_sh << 1;
         step    <= step + 1'b1;
         if (valid) running <= 1'b0;
      end
   end
endmodule

// File: rtl/countdown_game.sv
// Countdown game core: scaled popcount preview, BCD countdown at a prescaled
// tick rate, and a multiplexed seven-segment display with leading-zero blanking.
module countdown_game
   import countdown_pkg::*;
#(
   parameter int SW_W     = 8,
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 131072
) (
   input logic             clk,
   input logic             reset,
   countdown_game_if.slave bus
);
   localparam int CNT_W  = $clog2(SW_W + 1) + 4;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   if (10 ** DIGITS <= SW_W * 16) begin : g_bad_digits
      $error("countdown_game: DIGITS too small for SW_W*16");
   end
   if (TICK_DIV < 2 || SCAN_DIV < 1 || SW_W > 64) begin : g_bad_params
      $error("countdown_game: TICK_DIV>=2, SCAN_DIV>=1, SW_W<=64 required");
   end

   state_t            state;
   logic [BCD_W-1:0]  count;
   logic [BCD_W-1:0]  count_dec;
   logic [TICK_W-1:0] tick_cnt;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  digit_idx;
   logic [3:0]        digit;
   logic              nz_above;
   logic              blank;
   logic              conv_start;
   logic              conv_valid;
   logic [BCD_W-1:0]  conv_bcd;

   function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      logic             borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
            else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign count_dec  = bcd_dec(count);
   assign conv_start = bus.load && (state != ST_CONVERT);

   bin2bcd_seq #(.BIN_W(CNT_W), .DIGITS(DIGITS)) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (bus.led),
      .bcd   (conv_bcd),
      .valid (conv_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bus.led <= '0;
      else        bus.led <= CNT_W'(popcount(64'(bus.sw))) << mul_shift(bus.mul_sel);
   end

   // The converter samples led at the load edge, so a load during RUN restarts from the new preview.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         count    <= '0;
         tick_cnt <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (conv_start) begin
            state    <= ST_CONVERT;
            tick_cnt <= '0;
            bus.busy <= 1'b1;
         end else begin
            case (state)
               ST_CONVERT: if (conv_valid) begin
                  count    <= conv_bcd;
                  tick_cnt <= '0;
                  if (conv_bcd == '0) begin
                     state    <= ST_DONE;
                     bus.busy <= 1'b0;
                     bus.done <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
               ST_RUN: if (!bus.pause) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     count    <= count_dec;
                     if (count_dec == '0) begin
                        state    <= ST_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
         scan_cnt  <= scan_cnt + 1'b1;
      end
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      digit    = '0;
      nz_above = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IDX_W'(i) == digit_idx) digit = count[4*i +: 4];
         if (IDX_W'(i) >= digit_idx && count[4*i +: 4] != 4'd0) nz_above = 1'b1;
      end
      blank = (state == ST_IDLE) || (digit_idx != '0 && !nz_above);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.seg <= SEG_BLANK;
         bus.an  <= '1;
      end else if (blank) begin
         bus.seg <= SEG_BLANK;
         bus.an  <= '1;
      end else begin
         bus.seg <= seg_of(digit);
         bus.an  <= ~(DIGITS'(1) << digit_idx);
      end
   end
endmodule
